alu_sequencer: RTL and testbench

- Multi-cycle control unit that issues operations to the 8-bit ALU and consumes its results. This is the producer side of the ALU's ctrl/flag interface.
- Per instruction: fetches an 8-bit instruction over a req/valid handshake, decodes it into register-file read addresses and ALU ctrl/flag, then captures the ALU result and overflow and writes back to the register file.
- Sits between instruction memory, the 4-entry register file and the ALU in the 8-bit RISC core.

---
 rtl/alu_sequencer.sv | 150 +++++++++++++++
 tb/tb_alu_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle fetch/decode/execute/writeback controller
// that drives the 8-bit ALU and the 4-entry register file.
module alu_sequencer #(
   parameter logic [7:0] RESET_PC     = 8'h00,
   parameter bit         ILLEGAL_HALT = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       instr_req,
   output logic [7:0] instr_addr,
   input  logic       instr_valid,
   input  logic [7:0] instr_data,
   output logic [1:0] rf_ra1,
   output logic [1:0] rf_ra2,
   output logic [2:0] alu_ctrl,
   output logic       alu_flag,
   input  logic [7:0] alu_out,
   input  logic       alu_ovf,
   output logic       rf_we,
   output logic [1:0] rf_wa,
   output logic [7:0] rf_wd,
   output logic       ovf_flag,
   output logic       err,
   output logic       halt,
   output logic [7:0] pc
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_WB,
      S_HALTED
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] pc_q, pc_d;
   logic [7:0] ir_q, ir_d;
   logic [1:0] ra1_q, ra1_d;
   logic [1:0] ra2_q, ra2_d;
   logic [2:0] ctrl_q, ctrl_d;
   logic       flag_q, flag_d;
   logic [7:0] res_q, res_d;
   logic       ovf_q, ovf_d;
   logic       err_q, err_d;

   logic [2:0] op;
   logic       op_halt;
   logic       op_ill;

   assign op      = ir_q[7:5];
   assign op_halt = (op == 3'b111);
   assign op_ill  = (op == 3'b001) || (op == 3'b010) ||
                    (op == 3'b101) || (op == 3'b110);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         ir_q    <= 8'h00;
         ra1_q   <= 2'd0;
         ra2_q   <= 2'd0;
         ctrl_q  <= 3'b000;
         flag_q  <= 1'b0;
         res_q   <= 8'h00;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         ra1_q   <= ra1_d;
         ra2_q   <= ra2_d;
         ctrl_q  <= ctrl_d;
         flag_q  <= flag_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      ra1_d   = ra1_q;
      ra2_d   = ra2_q;
      ctrl_d  = ctrl_q;
      flag_d  = flag_q;
      res_d   = res_q;
      ovf_d   = ovf_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            if (instr_valid) begin
               ir_d    = instr_data;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            ra1_d  = ir_q[3:2];
            ra2_d  = ir_q[1:0];
            ctrl_d = op;
            flag_d = ir_q[4];
            unique case (1'b1)
               op_halt: state_d = S_HALTED;
               op_ill: begin
                  err_d = 1'b1;
                  if (ILLEGAL_HALT) begin
                     state_d = S_HALTED;
                  end else begin
                     pc_d    = pc_q + 8'd1;
                     state_d = S_FETCH;
                  end
               end
               default: state_d = S_EXEC;
            endcase
         end
         S_EXEC: begin
            res_d   = alu_out;
            // logic ops leave the ALU carry undefined, so never let it through
            ovf_d   = (ctrl_q == 3'b000) ? 1'b0 : alu_ovf;
            state_d = S_WB;
         end
         S_WB: begin
            pc_d    = pc_q + 8'd1;
            state_d = S_FETCH;
         end
         S_HALTED: state_d = S_HALTED;
         default:  state_d = S_IDLE;
      endcase
   end

   assign instr_req  = (state_q == S_FETCH);
   assign instr_addr = pc_q;
   assign rf_ra1     = ra1_q;
   assign rf_ra2     = ra2_q;
   assign alu_ctrl   = ctrl_q;
   assign alu_flag   = flag_q;
   assign rf_we      = (state_q == S_WB);
   assign rf_wa      = ra1_q;
   assign rf_wd      = res_q;
   assign ovf_flag   = ovf_q;
   assign err        = err_q;
   assign halt       = (state_q == S_HALTED);
   assign pc         = pc_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench with a behavioural ALU and
// register file around two sequencer instances (NOP and halting).
module tb_alu_sequencer;

   logic       clk;
   logic       rst_n;
   logic       instr_req;
   logic [7:0] instr_addr;
   logic       instr_valid;
   logic [7:0] instr_data;
   logic [1:0] rf_ra1, rf_ra2;
   logic [2:0] alu_ctrl;
   logic       alu_flag;
   logic [7:0] alu_out;
   logic       alu_ovf;
   logic       rf_we;
   logic [1:0] rf_wa;
   logic [7:0] rf_wd;
   logic       ovf_flag, err, halt;
   logic [7:0] pc;

   logic       h_instr_req;
   logic [7:0] h_instr_addr;
   logic       h_instr_valid;
   logic [7:0] h_instr_data;
   logic [1:0] h_rf_ra1, h_rf_ra2;
   logic [2:0] h_alu_ctrl;
   logic       h_alu_flag;
   logic       h_rf_we;
   logic [1:0] h_rf_wa;
   logic [7:0] h_rf_wd;
   logic       h_ovf_flag, h_err, h_halt;
   logic [7:0] h_pc;

   logic [7:0]  rf [4];
   logic [10:0] sb_q [$];
   int          checks = 0;
   int          errors = 0;
   logic        we_prev = 1'b0;

   alu_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .instr_req(instr_req), .instr_addr(instr_addr),
      .instr_valid(instr_valid), .instr_data(instr_data),
      .rf_ra1(rf_ra1), .rf_ra2(rf_ra2),
      .alu_ctrl(alu_ctrl), .alu_flag(alu_flag),
      .alu_out(alu_out), .alu_ovf(alu_ovf),
      .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
      .ovf_flag(ovf_flag), .err(err), .halt(halt), .pc(pc)
   );

   alu_sequencer #(.RESET_PC(8'h40), .ILLEGAL_HALT(1'b1)) dut_h (
      .clk(clk), .rst_n(rst_n),
      .instr_req(h_instr_req), .instr_addr(h_instr_addr),
      .instr_valid(h_instr_valid), .instr_data(h_instr_data),
      .rf_ra1(h_rf_ra1), .rf_ra2(h_rf_ra2),
      .alu_ctrl(h_alu_ctrl), .alu_flag(h_alu_flag),
      .alu_out(8'h00), .alu_ovf(1'b0),
      .rf_we(h_rf_we), .rf_wa(h_rf_wa), .rf_wd(h_rf_wd),
      .ovf_flag(h_ovf_flag), .err(h_err), .halt(h_halt), .pc(h_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural ALU; logic ops drive an undefined or junk carry
   always_comb begin
      logic [7:0] a, b;
      a       = rf[rf_ra1];
      b       = rf[rf_ra2];
      alu_out = 8'h00;
      alu_ovf = 1'b0;
      case (alu_ctrl)
         3'b000: begin
            alu_out = alu_flag ? ~(a & b) : ~(a | b);
            alu_ovf = alu_flag ? 1'bx : 1'b1;
         end
         3'b011: begin
            if (alu_flag) {alu_ovf, alu_out} = {1'b0, a} - {1'b0, b};
            else          {alu_ovf, alu_out} = {1'b0, a} + {1'b0, b};
         end
         3'b100: begin
            alu_out = alu_flag ? (a << b[2:0]) : (a >> b[2:0]);
            alu_ovf = alu_flag ? a[7] : a[0];
         end
         default: ;
      endcase
   end

   always @(negedge clk) begin
      if (rf_we === 1'b1) begin
         logic [10:0] exp;
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write wa=%0d wd=%h expected none",
                     rf_wa, rf_wd);
         end else begin
            exp = sb_q.pop_front();
            if ({rf_wa, rf_wd, ovf_flag} !== exp) begin
               errors++;
               $display("FAIL writeback got wa=%0d wd=%h ovf=%b exp wa=%0d wd=%h ovf=%b",
                        rf_wa, rf_wd, ovf_flag, exp[10:9], exp[8:1], exp[0]);
            end
         end
         checks++;
         if (we_prev) begin
            errors++;
            $display("FAIL we_width rf_we high two cycles, expected one");
         end
      end
      if (h_rf_we !== 1'b0) begin
         checks++;
         errors++;
         $display("FAIL h_write rf_we=%b expected 0", h_rf_we);
      end
      we_prev = (rf_we === 1'b1);
   end

   task automatic fetch(input logic [7:0] ins, input int waits,
                        input logic [7:0] addr);
      int n = 0;
      while (instr_req !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (instr_req !== 1'b1) begin
         errors++;
         $display("FAIL fetch_timeout instr_req=%b expected 1", instr_req);
      end
      checks++;
      if (instr_addr !== addr) begin
         errors++;
         $display("FAIL fetch_addr got %h expected %h", instr_addr, addr);
      end
      for (int i = 0; i < waits; i++) begin
         instr_data = ins;
         @(negedge clk);
         checks++;
         if (instr_req !== 1'b1 || instr_addr !== addr) begin
            errors++;
            $display("FAIL wait_stable req=%b addr=%h expected 1/%h",
                     instr_req, instr_addr, addr);
         end
      end
      instr_valid = 1'b1;
      instr_data  = ins;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      instr_data  = 8'h00;
   endtask

   task automatic run_op(input logic [7:0] ins, input logic [7:0] addr,
                         input logic [1:0] wa, input logic [7:0] wd,
                         input logic ovf);
      logic [7:0] nxt;
      nxt = addr + 8'd1;
      sb_q.push_back({wa, wd, ovf});
      fetch(ins, 0, addr);
      repeat (3) @(negedge clk);
      checks++;
      if (rf_we !== 1'b1) begin
         errors++;
         $display("FAIL wb_latency rf_we=%b expected 1 at handshake+3", rf_we);
      end
      @(negedge clk);
      checks++;
      if (rf_we !== 1'b0) begin
         errors++;
         $display("FAIL wb_pulse rf_we=%b expected 0", rf_we);
      end
      checks++;
      if (pc !== nxt) begin
         errors++;
         $display("FAIL pc_inc got %h expected %h", pc, nxt);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      checks++;
      if ({instr_req, rf_we, ovf_flag, err, halt, alu_flag, alu_ctrl,
           rf_ra1, rf_ra2, rf_wa, rf_wd, pc} !== 30'd0) begin
         errors++;
         $display("FAIL %s req=%b we=%b ovf=%b err=%b halt=%b fl=%b ctrl=%b ra=%0d/%0d wa=%0d wd=%h pc=%h expected all 0",
                  tag, instr_req, rf_we, ovf_flag, err, halt, alu_flag,
                  alu_ctrl, rf_ra1, rf_ra2, rf_wa, rf_wd, pc);
      end
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      instr_valid   = 1'b0;
      instr_data    = 8'h00;
      h_instr_valid = 1'b0;
      h_instr_data  = 8'h00;
      repeat (2) @(negedge clk);
      chk_reset_vals("reset_vals");
      checks++;
      if (h_pc !== 8'h40 || h_instr_req !== 1'b0) begin
         errors++;
         $display("FAIL h_reset pc=%h req=%b expected 40/0", h_pc, h_instr_req);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (instr_req !== 1'b0) begin
         errors++;
         $display("FAIL idle_req instr_req=%b expected 0", instr_req);
      end
      @(negedge clk);
      checks++;
      if (instr_req !== 1'b1 || instr_addr !== 8'h00) begin
         errors++;
         $display("FAIL first_fetch req=%b addr=%h expected 1/00",
                  instr_req, instr_addr);
      end
   endtask

   task automatic test_illegal_halt();
      checks++;
      if (h_instr_req !== 1'b1 || h_instr_addr !== 8'h40) begin
         errors++;
         $display("FAIL h_fetch req=%b addr=%h expected 1/40",
                  h_instr_req, h_instr_addr);
      end
      h_instr_valid = 1'b1;
      h_instr_data  = 8'h40;
      @(posedge clk);
      #1 h_instr_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({h_halt, h_err, h_instr_req, h_pc} !== {3'b110, 8'h40}) begin
         errors++;
         $display("FAIL h_illegal halt=%b err=%b req=%b pc=%h expected 1/1/0/40",
                  h_halt, h_err, h_instr_req, h_pc);
      end
   endtask

   task automatic test_add();
      rf[1] = 8'hF0;
      rf[2] = 8'h20;
      run_op(8'h66, 8'h00, 2'd1, 8'h10, 1'b1);
      checks++;
      if ({alu_ctrl, alu_flag, rf_ra1, rf_ra2} !== {3'b011, 1'b0, 2'd1, 2'd2}) begin
         errors++;
         $display("FAIL add_decode ctrl=%b flag=%b ra1=%0d ra2=%0d expected 011/0/1/2",
                  alu_ctrl, alu_flag, rf_ra1, rf_ra2);
      end
      checks++;
      if (ovf_flag !== 1'b1) begin
         errors++;
         $display("FAIL add_ovf ovf_flag=%b expected 1", ovf_flag);
      end
   endtask

   task automatic test_logic_ops();
      rf[0] = 8'hFF;
      rf[3] = 8'h0F;
      run_op(8'h13, 8'h01, 2'd0, 8'hF0, 1'b0);
      checks++;
      if (ovf_flag !== 1'b0) begin
         errors++;
         $display("FAIL nand_ovf ovf_flag=%b expected 0", ovf_flag);
      end
      rf[0] = 8'hF0;
      run_op(8'h03, 8'h02, 2'd0, 8'h00, 1'b0);
   endtask

   task automatic test_illegal_nop();
      fetch(8'h40, 3, 8'h03);
      repeat (2) @(negedge clk);
      checks++;
      if ({err, halt, instr_req, pc} !== {3'b101, 8'h04}) begin
         errors++;
         $display("FAIL illegal_nop err=%b halt=%b req=%b pc=%h expected 1/0/1/04",
                  err, halt, instr_req, pc);
      end
   endtask

   task automatic test_wrap();
      for (int i = 4; i < 255; i++) fetch(8'h40, 0, 8'(i));
      rf[2] = 8'h81;
      rf[3] = 8'h01;
      run_op(8'h9B, 8'hFF, 2'd2, 8'h02, 1'b1);
      rf[2] = 8'h02;
      run_op(8'h7B, 8'h00, 2'd2, 8'h01, 1'b0);
      checks++;
      if (ovf_flag !== 1'b0 || err !== 1'b1) begin
         errors++;
         $display("FAIL back_to_back ovf=%b err=%b expected 0/1", ovf_flag, err);
      end
   endtask

   task automatic test_halt();
      fetch(8'hE0, 0, 8'h01);
      @(negedge clk);
      instr_valid = 1'b1;
      instr_data  = 8'h66;
      repeat (10) begin
         @(negedge clk);
         checks++;
         if ({halt, instr_req, pc} !== {2'b10, 8'h01}) begin
            errors++;
            $display("FAIL halted halt=%b req=%b pc=%h expected 1/0/01",
                     halt, instr_req, pc);
         end
      end
      instr_valid = 1'b0;
      instr_data  = 8'h00;
   endtask

   task automatic test_reset_mid();
      rst_n = 1'b0;
      #1 chk_reset_vals("reset_from_halt");
      @(posedge clk);
      #1 rst_n = 1'b1;
      rf[1] = 8'hF0;
      rf[2] = 8'h20;
      fetch(8'h66, 0, 8'h00);
      @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("reset_mid_exec");
      repeat (3) @(negedge clk);
      chk_reset_vals("reset_held");
      @(posedge clk);
      #1 rst_n = 1'b1;
      rf[1] = 8'h11;
      rf[2] = 8'h01;
      run_op(8'h86, 8'h00, 2'd1, 8'h08, 1'b1);
   endtask

   initial begin
      test_reset();
      test_illegal_halt();
      test_add();
      test_logic_ops();
      test_illegal_nop();
      test_wrap();
      test_halt();
      test_reset_mid();
      repeat (2) @(negedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL pending_writes left=%0d expected 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
